// File: rtl/ls_wb_stage_pkg.sv
// Shared types and opcode constants for the LS -> write-back boundary stage.
// Entry layout is fixed at the default 64-bit datapath / 32-bit instruction width.
package ls_wb_stage_pkg;

    localparam int WB_XLEN = 64;
    localparam int WB_ILEN = 32;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_OP32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [WB_XLEN-1:0] pc;
        logic [WB_ILEN-1:0] instr;
        logic [4:0]         rd;
        logic               wen;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    function automatic logic opc_writes_rd(input logic [4:0] opc);
        return opc inside {OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_OP32, OPC_OP_IMM32,
                           OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
    endfunction

endpackage

// File: rtl/ls_wb_stage_wb_dec.sv
// Write-back decode: register write enable, destination and the selected result
// (load data, link address or ALU result) for one retiring instruction.
module ls_wb_stage_wb_dec
    import ls_wb_stage_pkg::*;
#(
    parameter int XLEN = WB_XLEN
) (
    input  logic [4:0]      opcode_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] alures_i,
    input  logic [XLEN-1:0] ls_res_i,
    output logic            wen_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] data_o
);

    // NOTE: every output gets a default before the case so no latch can be inferred.
    always_comb begin
        wen_o  = opc_writes_rd(opcode_i) && (rd_i != 5'd0);
        rd_o   = rd_i;
        data_o = alures_i;
        case (opcode_i)
            OPC_LOAD:          data_o = ls_res_i;
            OPC_JAL, OPC_JALR: data_o = pc_i + XLEN'(4);
            default:           data_o = alures_i;
        endcase
    end

endmodule

// File: rtl/ls_wb_stage.sv
// Two-entry skid buffer between the load/store stage and register write-back,
// with forwarding lookup into both held entries and a retire counter.
module ls_wb_stage
    import ls_wb_stage_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int ILEN = WB_ILEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [ILEN-1:0] instr_i,
    input  logic [XLEN-1:0] alures_i,
    input  logic [XLEN-1:0] ls_res_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] wb_pc_o,
    output logic [ILEN-1:0] wb_instr_o,
    output logic            wb_wen_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    input  logic [4:0]      fwd_rs_i,
    output logic            fwd_hit_o,
    output logic [XLEN-1:0] fwd_data_o,
    output logic [63:0]     retire_cnt_o
);

    state_e    state_q, state_d;
    wb_entry_t main_q, main_d;
    wb_entry_t skid_q, skid_d;
    logic [63:0] retire_q, retire_d;
    wb_entry_t in_entry;
    logic in_fire, out_fire;

    ls_wb_stage_wb_dec #(.XLEN(XLEN)) u_wb_dec (
        .opcode_i (instr_i[6:2]),
        .rd_i     (instr_i[11:7]),
        .pc_i     (pc_i),
        .alures_i (alures_i),
        .ls_res_i (ls_res_i),
        .wen_o    (in_entry.wen),
        .rd_o     (in_entry.rd),
        .data_o   (in_entry.data)
    );

    assign in_entry.pc    = pc_i;
    assign in_entry.instr = instr_i;

    // Ready depends only on registered state, so write-back stall never reaches LS combinationally.
    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        retire_d = retire_q + {63'd0, out_fire};
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_entry;
                end else if (in_fire) begin
                    skid_d  = in_entry;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush only invalidates; stale entry contents are masked by the state.
        if (flush_i) begin
            state_d = EMPTY;
        end
    end

    // NOTE: state uses non-blocking assignments; the entry storage is reset too because wb_* must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            retire_q <= retire_d;
        end
    end

    assign wb_pc_o      = main_q.pc;
    assign wb_instr_o   = main_q.instr;
    assign wb_wen_o     = main_q.wen;
    assign wb_rd_o      = main_q.rd;
    assign wb_data_o    = main_q.data;
    assign retire_cnt_o = retire_q;

    // Skid holds the younger instruction, so its value wins on a double hit.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        if (fwd_rs_i != 5'd0) begin
            if (state_q == FULL && skid_q.wen && skid_q.rd == fwd_rs_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = skid_q.data;
            end else if (state_q != EMPTY && main_q.wen && main_q.rd == fwd_rs_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = main_q.data;
            end
        end
    end

endmodule

// File: tb/tb_ls_wb_stage.sv
// Self-checking bench for ls_wb_stage: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_ls_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] pc_i;
    logic [31:0] instr_i;
    logic [63:0] alures_i;
    logic [63:0] ls_res_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] wb_pc_o;
    logic [31:0] wb_instr_o;
    logic        wb_wen_o;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_o;
    logic [4:0]  fwd_rs_i;
    logic        fwd_hit_o;
    logic [63:0] fwd_data_o;
    logic [63:0] retire_cnt_o;

    ls_wb_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .pc_i         (pc_i),
        .instr_i      (instr_i),
        .alures_i     (alures_i),
        .ls_res_i     (ls_res_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .wb_pc_o      (wb_pc_o),
        .wb_instr_o   (wb_instr_o),
        .wb_wen_o     (wb_wen_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .fwd_rs_i     (fwd_rs_i),
        .fwd_hit_o    (fwd_hit_o),
        .fwd_data_o   (fwd_data_o),
        .retire_cnt_o (retire_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] data;
    } exp_t;

    exp_t        model_q[$];
    logic [63:0] model_retire;
    int          n_checks;
    int          n_fail;

    logic [4:0] opcs [12] = '{5'b00000, 5'b00100, 5'b00101, 5'b00110, 5'b01000, 5'b01100,
                              5'b01101, 5'b01110, 5'b11000, 5'b11001, 5'b11011, 5'b11100};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected write-back entry computed straight from the decode rules.
    function automatic exp_t make_exp(input logic [31:0] ins, input logic [63:0] pc,
                                      input logic [63:0] alu, input logic [63:0] ls);
        exp_t e;
        logic [4:0] op;
        op       = ins[6:2];
        e.pc     = pc;
        e.instr  = ins;
        e.rd     = ins[11:7];
        e.wen    = (op inside {5'b00000, 5'b01100, 5'b00100, 5'b01110, 5'b00110,
                               5'b01101, 5'b00101, 5'b11011, 5'b11001}) && (e.rd != 5'd0);
        if (op == 5'b00000)                         e.data = ls;
        else if (op == 5'b11011 || op == 5'b11001)  e.data = pc + 64'd4;
        else                                        e.data = alu;
        return e;
    endfunction

    task automatic check_outputs();
        logic        exp_hit;
        logic [63:0] exp_fwd;
        check("out_valid", 64'(out_valid_o), 64'(model_q.size() > 0));
        check("in_ready", 64'(in_ready_o), 64'(model_q.size() < 2));
        check("retire", retire_cnt_o, model_retire);
        if (model_q.size() > 0) begin
            check("wb_pc", wb_pc_o, model_q[0].pc);
            check("wb_instr", 64'(wb_instr_o), 64'(model_q[0].instr));
            check("wb_wen", 64'(wb_wen_o), 64'(model_q[0].wen));
            check("wb_rd", 64'(wb_rd_o), 64'(model_q[0].rd));
            check("wb_data", wb_data_o, model_q[0].data);
        end
        exp_hit = 1'b0;
        exp_fwd = '0;
        if (fwd_rs_i != 5'd0) begin
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (!exp_hit && model_q[i].wen && model_q[i].rd == fwd_rs_i) begin
                    exp_hit = 1'b1;
                    exp_fwd = model_q[i].data;
                end
            end
        end
        check("fwd_hit", 64'(fwd_hit_o), 64'(exp_hit));
        check("fwd_data", fwd_data_o, exp_fwd);
    endtask

    // One cycle: drive at negedge, compare, then advance the model at the rising edge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic [63:0] alu, input logic [63:0] ls,
                        input bit ordy, input bit fl, input logic [4:0] rs);
        bit m_in_fire, m_out_fire;
        @(negedge clk);
        in_valid_i  = v;
        instr_i     = ins;
        pc_i        = pc;
        alures_i    = alu;
        ls_res_i    = ls;
        out_ready_i = ordy;
        flush_i     = fl;
        fwd_rs_i    = rs;
        #1;
        check_outputs();
        @(posedge clk);
        m_in_fire  = v && (model_q.size() < 2);
        m_out_fire = ordy && (model_q.size() > 0);
        if (m_out_fire) begin
            void'(model_q.pop_front());
            model_retire++;
        end
        if (fl)             model_q.delete();
        else if (m_in_fire) model_q.push_back(make_exp(ins, pc, alu, ls));
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, ordy, 1'b0, 5'd0);
    endtask

    task automatic random_steps(input int n);
        logic [31:0] ins;
        logic [4:0]  op;
        int          r;
        for (int i = 0; i < n; i++) begin
            r   = int'($urandom_range(0, 13));
            op  = (r < 12) ? opcs[r] : 5'($urandom);
            ins = {20'($urandom), 5'($urandom_range(0, 7)), op, 2'b11};
            step($urandom_range(0, 2) != 0, ins,
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                 5'($urandom_range(0, 7)));
        end
    endtask

    logic [63:0] base_retire;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        model_retire = '0;
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        in_valid_i   = 1'b0;
        pc_i         = '0;
        instr_i      = '0;
        alures_i     = '0;
        ls_res_i     = '0;
        out_ready_i  = 1'b0;
        fwd_rs_i     = 5'd0;
        #1;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_retire", retire_cnt_o, 64'd0);
        check("rst_wb_wen", 64'(wb_wen_o), 64'd0);
        check("rst_wb_rd", 64'(wb_rd_o), 64'd0);
        check("rst_wb_data", wb_data_o, 64'd0);
        check("rst_wb_pc", wb_pc_o, 64'd0);
        check("rst_wb_instr", 64'(wb_instr_o), 64'd0);
        check("rst_fwd_hit", 64'(fwd_hit_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);

        // ADDI x5, x0, 10
        step(1'b1, 32'h00A00293, 64'h1000, 64'hA, 64'h0, 1'b1, 1'b0, 5'd5);
        #2;
        check("addi_valid", 64'(out_valid_o), 64'd1);
        check("addi_rd", 64'(wb_rd_o), 64'd5);
        check("addi_wen", 64'(wb_wen_o), 64'd1);
        check("addi_data", wb_data_o, 64'hA);
        idle(1'b1);
        #2;
        check("addi_retire", retire_cnt_o, 64'd1);

        // LD x6: load data wins over the effective address
        step(1'b1, 32'h00053303, 64'h1004, 64'h80000010, 64'hDEADBEEF, 1'b1, 1'b0, 5'd6);
        #2;
        check("ld_data", wb_data_o, 64'hDEADBEEF);
        idle(1'b1);

        // JAL x1 writes the link address
        step(1'b1, 32'h000000EF, 64'h80000000, 64'h1234, 64'h0, 1'b1, 1'b0, 5'd1);
        #2;
        check("jal_data", wb_data_o, 64'h80000004);
        idle(1'b1);

        // SD and ADDI x0 never write
        step(1'b1, 32'h00B53023, 64'h2000, 64'h55, 64'h0, 1'b1, 1'b0, 5'd0);
        #2;
        check("sd_wen", 64'(wb_wen_o), 64'd0);
        step(1'b1, 32'h00000013, 64'h2004, 64'h77, 64'h0, 1'b1, 1'b0, 5'd0);
        #2;
        check("x0_wen", 64'(wb_wen_o), 64'd0);
        check("x0_fwd_hit", 64'(fwd_hit_o), 64'd0);
        idle(1'b1);

        // Back-pressure: two writes to x7, skid must win the forward lookup
        base_retire = model_retire;
        step(1'b1, 32'h00100393, 64'h3000, 64'd1, 64'h0, 1'b0, 1'b0, 5'd7);
        step(1'b1, 32'h00200393, 64'h3004, 64'd2, 64'h0, 1'b0, 1'b0, 5'd7);
        #2;
        check("bp_in_ready", 64'(in_ready_o), 64'd0);
        fwd_rs_i = 5'd7;
        #1;
        check("bp_fwd_hit", 64'(fwd_hit_o), 64'd1);
        check("bp_fwd_data", fwd_data_o, 64'd2);
        idle(1'b1);
        idle(1'b1);
        #2;
        check("bp_retire", retire_cnt_o, base_retire + 64'd2);

        // Flush while full with a competing input
        step(1'b1, 32'h00100413, 64'h4000, 64'd11, 64'h0, 1'b0, 1'b0, 5'd8);
        step(1'b1, 32'h00200413, 64'h4004, 64'd12, 64'h0, 1'b0, 1'b0, 5'd8);
        base_retire = model_retire;
        step(1'b1, 32'h00300413, 64'h4008, 64'd13, 64'h0, 1'b0, 1'b1, 5'd8);
        #2;
        check("fl_out_valid", 64'(out_valid_o), 64'd0);
        check("fl_in_ready", 64'(in_ready_o), 64'd1);
        check("fl_retire", retire_cnt_o, base_retire);
        idle(1'b1);
        idle(1'b1);

        random_steps(400);

        // Asynchronous reset mid-cycle with entries held
        step(1'b1, 32'h00100493, 64'h5000, 64'd21, 64'h0, 1'b0, 1'b0, 5'd9);
        step(1'b1, 32'h00200493, 64'h5004, 64'd22, 64'h0, 1'b0, 1'b0, 5'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid_o), 64'd0);
        check("arst_in_ready", 64'(in_ready_o), 64'd1);
        check("arst_wb_data", wb_data_o, 64'd0);
        check("arst_retire", retire_cnt_o, 64'd0);
        check("arst_fwd_hit", 64'(fwd_hit_o), 64'd0);
        model_q.delete();
        model_retire = '0;
        #1;
        rst_n = 1'b1;

        random_steps(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ls_wb_stage.md
Name: ls_wb_stage

Overview:
- Pipeline boundary between the load/store stage and register-file write-back.
- Captures each retiring LS-stage instruction and selects its write-back value: load result, link address, or ALU result.
- Buffers up to two entries in a skid buffer, so back-pressure from write-back never combinationally reaches the LS stage.
- Provides a forwarding lookup into both buffered entries and a retire counter.

Parameters:
- XLEN, 64, datapath width.
- ILEN, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous kill of all buffered entries.
- in_valid_i  in  1  LS stage presents an instruction.
- in_ready_o  out  1  stage can accept an instruction this cycle.
- pc_i  in  XLEN  PC of the incoming instruction.
- instr_i  in  ILEN  incoming instruction word.
- alures_i  in  XLEN  ALU result / effective address.
- ls_res_i  in  XLEN  extended load data from the LS stage.
- out_valid_o  out  1  write-back entry valid.
- out_ready_i  in  1  write-back consumes the entry.
- wb_pc_o  out  XLEN  PC of the head entry.
- wb_instr_o  out  ILEN  instruction of the head entry.
- wb_wen_o  out  1  register-file write enable; only meaningful with out_valid_o.
- wb_rd_o  out  5  destination register.
- wb_data_o  out  XLEN  write-back data.
- fwd_rs_i  in  5  source register to look up.
- fwd_hit_o  out  1  a buffered entry writes fwd_rs_i.
- fwd_data_o  out  XLEN  forwarded data.
- retire_cnt_o  out  64  count of consumed entries.

Behaviour:
- Handshakes: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Decode at capture, from instr_i[6:2]:
  - wen=1 for LOAD, OP, OP-IMM, OP-32, OP-IMM-32, LUI, AUIPC, JAL, JALR.
  - wen is forced to 0 when rd=instr_i[11:7] is 0.
  - STORE, BRANCH, SYSTEM and all other opcodes give wen=0.
- Data select at capture: LOAD -> ls_res_i; JAL/JALR -> pc_i+4 (XLEN wrap); else alures_i.
- Storage: two entries, main (head) and skid. Each holds pc, instr, rd, wen, data.
- State machine (2-bit):
  - EMPTY:
    - in_fire -> ONE, main <= input.
  - ONE:
    - in_fire & out_fire -> ONE, main <= input.
    - in_fire & !out_fire -> FULL, skid <= input.
    - out_fire only -> EMPTY.
  - FULL:
    - out_fire -> ONE, main <= skid.
    - in_fire is impossible in FULL.
- Ready/valid:
  - in_ready_o = (state != FULL), a function of state only.
  - out_valid_o = (state != EMPTY).
  - wb_* outputs are driven from main only.
- Latency: 1 cycle from in_fire to out_valid_o when the stage was empty.
- Ordering: strict FIFO; the skid entry is always younger than main.
- flush_i:
  - Next state is EMPTY and entries are invalidated.
  - An in_fire in the same cycle is discarded.
  - retire_cnt_o still counts an out_fire in the same cycle.
- Forwarding (combinational):
  - A hit requires a valid entry with wen=1 and rd == fwd_rs_i, with fwd_rs_i != 0.
  - If both entries hit, skid (younger) has priority.
  - When there is no hit, fwd_data_o = 0.
- retire_cnt_o: +1 on each out_fire; wraps at 2^64.
- Reset (async assert, sync deassert handled outside the block):
  - state=EMPTY, so out_valid_o=0 and in_ready_o=1.
  - All entry fields are 0, so wb_wen_o=0, wb_rd_o=0, wb_data_o=0, wb_pc_o=0, wb_instr_o=0.
  - retire_cnt_o=0, fwd_hit_o=0.
- A reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - opcode constants (instr[6:2]): LOAD 00000, OP_IMM 00100, AUIPC 00101, OP_IMM32 00110, STORE 01000, OP 01100, LUI 01101, OP32 01110, BRANCH 11000, JALR 11001, JAL 11011, SYSTEM 11100.
  - state enum {EMPTY, ONE, FULL}.
  - the wb_entry_t struct.
- One sub-module, wb_dec: combinational decode of instr/pc/alures/ls_res into {wen, rd, data}.

Test Plan:
- Reset then idle: out_valid_o=0, in_ready_o=1, retire_cnt_o=0.
- Single ADDI x5 (instr 0x00A00293), alures=0xA, out_ready=1:
  - Expect out_valid_o one cycle later.
  - Expect wb_rd_o=5, wb_wen_o=1, wb_data_o=0xA.
  - Expect retire_cnt_o=1 afterwards.
- LD x6 with ls_res=0xDEADBEEF and alures=0x80000010 -> wb_data_o=0xDEADBEEF.
- JAL x1 at pc=0x80000000 -> wb_data_o=0x80000004.
- SD (instr 0x00B53023) -> wb_wen_o=0.
- Any instruction with rd=x0 -> wb_wen_o=0, and fwd_rs_i=0 never hits.
- Back-pressure, out_ready=0 while feeding A (x7=1) then B (x7=2):
  - After the second fire, in_ready_o=0 (FULL).
  - fwd_rs_i=7 returns hit with data 2 (skid priority).
  - Release out_ready: A then B drain in order, retire_cnt_o=2.
- flush_i in FULL with in_valid_i=1:
  - Next cycle out_valid_o=0 and in_ready_o=1.
  - The flushed input never appears at the output.
  - retire_cnt_o is unchanged.
